kf6845_vram_arbiter: RTL and testbench

- Shares one single-port synchronous video RAM between the KF6845 refresh fetch and a CPU access port.
- Each character period (one `video_clock_enable` pulse) gives two time slots to the CRTC: a character-code fetch at {MA,0} and an attribute fetch at {MA,1}.
- All other cycles, and every cycle while the display is disabled, are available to the CPU.
- Sits between the KF6845 (MA/DE) and the VRAM macro, and feeds the character/attribute pipeline of the pixel generator.

---
 rtl/kf6845_vram_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_kf6845_vram_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kf6845_vram_arbiter.sv
// kf6845_vram_arbiter
// Time-multiplexes one single-port synchronous video RAM between the KF6845
// refresh fetch (character code + attribute per character period) and a CPU
// access port. Video slots always win; the CPU gets every other cycle.
// RAM read data arrives one cycle after the address, so completion is steered
// by a one-deep issue tag registered at the end of each issue cycle.

`timescale 1ns/1ps

module kf6845_vram_arbiter #(
    parameter int MA_WIDTH         = 14,
    parameter int DATA_WIDTH       = 8,
    parameter int BLANK_CPU_ACCESS = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  video_clock_enable,
    input  logic [MA_WIDTH-1:0]   crtc_ma,
    input  logic                  crtc_de,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [MA_WIDTH:0]     cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic [MA_WIDTH:0]     vram_addr,
    output logic                  vram_we,
    output logic [DATA_WIDTH-1:0] vram_wdata,
    input  logic [DATA_WIDTH-1:0] vram_rdata,
    output logic [DATA_WIDTH-1:0] char_code,
    output logic [DATA_WIDTH-1:0] attr_code,
    output logic                  fetch_valid
);

    // What the RAM is doing on behalf of whom in the previous cycle.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CHAR = 2'd1,
        TAG_ATTR = 2'd2,
        TAG_CPU  = 2'd3
    } tag_t;

    localparam logic [1:0] PHASE_CHAR = 2'd0;
    localparam logic [1:0] PHASE_ATTR = 2'd1;
    localparam logic [1:0] PHASE_LAST = 2'd3;

    // Character-period state
    logic [1:0]            phase_r;
    logic                  de_lat_r;

    // Cleared by reset and set on the first clock after release, so nothing
    // (in particular no write strobe) reaches the RAM while reset is active.
    logic                  armed_r;

    // Issue pipeline (one deep)
    tag_t                  tag_r;
    logic                  tag_we_r;
    logic [MA_WIDTH:0]     addr_hold_r;
    logic [DATA_WIDTH-1:0] wdata_hold_r;

    // Completion holding registers
    logic [DATA_WIDTH-1:0] cpu_rdata_hold_r;
    logic [DATA_WIDTH-1:0] char_hold_r;
    logic [DATA_WIDTH-1:0] attr_hold_r;

    // Slot decisions for the current cycle
    logic                  video_allowed_s;
    logic                  char_slot_s;
    logic                  attr_slot_s;
    logic                  cpu_slot_s;
    tag_t                  next_tag_s;

    // Slot decode: video slots in phases 0/1 when displaying, CPU otherwise.
    always_comb begin
        if (BLANK_CPU_ACCESS == 0) begin
            video_allowed_s = 1'b1;
        end else begin
            video_allowed_s = de_lat_r;
        end
        char_slot_s = armed_r && video_allowed_s && (phase_r == PHASE_CHAR);
        attr_slot_s = armed_r && video_allowed_s && (phase_r == PHASE_ATTR);
        // The ack cycle blocks re-issue so a held request is not served twice.
        cpu_slot_s  = armed_r && !char_slot_s && !attr_slot_s && cpu_req
                      && (tag_r != TAG_CPU);
    end

    // RAM port mux; idle cycles keep the last address and never write.
    always_comb begin
        next_tag_s = TAG_NONE;
        vram_addr  = addr_hold_r;
        vram_we    = 1'b0;
        vram_wdata = wdata_hold_r;
        if (char_slot_s) begin
            next_tag_s = TAG_CHAR;
            vram_addr  = {crtc_ma, 1'b0};
        end else if (attr_slot_s) begin
            next_tag_s = TAG_ATTR;
            vram_addr  = {crtc_ma, 1'b1};
        end else if (cpu_slot_s) begin
            next_tag_s = TAG_CPU;
            vram_addr  = cpu_addr;
            vram_we    = cpu_we;
            vram_wdata = cpu_wdata;
        end else begin
            next_tag_s = TAG_NONE;
        end
    end

    // Phase counter restarts on every strobe and saturates at 3; DE is latched
    // once per character period at the edge entering phase 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_r  <= PHASE_LAST;
            de_lat_r <= 1'b0;
        end else if (video_clock_enable) begin
            phase_r  <= PHASE_CHAR;
            de_lat_r <= crtc_de;
        end else if (phase_r != PHASE_LAST) begin
            phase_r  <= phase_r + 2'd1;
        end else begin
            phase_r  <= phase_r;
        end
    end

    // Arms the issue logic one clock after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            armed_r <= 1'b0;
        end else begin
            armed_r <= 1'b1;
        end
    end

    // Registers the issue tag and the address/data last presented to the RAM.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_r        <= TAG_NONE;
            tag_we_r     <= 1'b0;
            addr_hold_r  <= {(MA_WIDTH + 1){1'b0}};
            wdata_hold_r <= {DATA_WIDTH{1'b0}};
        end else begin
            tag_r    <= next_tag_s;
            tag_we_r <= cpu_slot_s && cpu_we;
            if (next_tag_s != TAG_NONE) begin
                addr_hold_r <= vram_addr;
            end else begin
                addr_hold_r <= addr_hold_r;
            end
            if (cpu_slot_s) begin
                wdata_hold_r <= cpu_wdata;
            end else begin
                wdata_hold_r <= wdata_hold_r;
            end
        end
    end

    // Captures returning RAM data according to the tag of the completing access.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cpu_rdata_hold_r <= {DATA_WIDTH{1'b0}};
            char_hold_r      <= {DATA_WIDTH{1'b0}};
            attr_hold_r      <= {DATA_WIDTH{1'b0}};
        end else begin
            case (tag_r)
                TAG_CHAR: char_hold_r <= vram_rdata;
                TAG_ATTR: attr_hold_r <= vram_rdata;
                TAG_CPU: begin
                    if (!tag_we_r) begin
                        cpu_rdata_hold_r <= vram_rdata;
                    end else begin
                        cpu_rdata_hold_r <= cpu_rdata_hold_r;
                    end
                end
                default: begin
                    cpu_rdata_hold_r <= cpu_rdata_hold_r;
                end
            endcase
        end
    end

    // Completion outputs: strobes decode the registered tag; the data that
    // completes this cycle is forwarded so it is valid alongside its strobe.
    always_comb begin
        cpu_ack     = (tag_r == TAG_CPU);
        fetch_valid = (tag_r == TAG_ATTR);
        char_code   = char_hold_r;
        if ((tag_r == TAG_CPU) && !tag_we_r) begin
            cpu_rdata = vram_rdata;
        end else begin
            cpu_rdata = cpu_rdata_hold_r;
        end
        if (tag_r == TAG_ATTR) begin
            attr_code = vram_rdata;
        end else begin
            attr_code = attr_hold_r;
        end
    end

endmodule

// File: tb/tb_kf6845_vram_arbiter.sv
// Directed self-checking bench for kf6845_vram_arbiter with a behavioural
// synchronous RAM (one-cycle read latency, read-before-write).

`timescale 1ns/1ps

module tb_kf6845_vram_arbiter;

    logic        clock;
    logic        reset_n;
    logic        video_clock_enable;
    logic [13:0] crtc_ma;
    logic        crtc_de;
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [14:0] vram_addr;
    logic        vram_we;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata;
    logic [7:0]  char_code;
    logic [7:0]  attr_code;
    logic        fetch_valid;

    int checks = 0;
    int errors = 0;

    kf6845_vram_arbiter #(
        .MA_WIDTH(14),
        .DATA_WIDTH(8),
        .BLANK_CPU_ACCESS(1)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .video_clock_enable(video_clock_enable),
        .crtc_ma(crtc_ma),
        .crtc_de(crtc_de),
        .cpu_req(cpu_req),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack),
        .cpu_rdata(cpu_rdata),
        .vram_addr(vram_addr),
        .vram_we(vram_we),
        .vram_wdata(vram_wdata),
        .vram_rdata(vram_rdata),
        .char_code(char_code),
        .attr_code(attr_code),
        .fetch_valid(fetch_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural VRAM
    logic [7:0] mem [0:32767];
    logic       mem_ready = 1'b0;

    function automatic logic [7:0] preload(input int a);
        logic [7:0] v;
        case (a)
            5:       v = 8'h37;
            'h0246:  v = 8'h41;
            'h0247:  v = 8'h1F;
            1:       v = 8'h11;
            2:       v = 8'h22;
            default: v = a[7:0] ^ 8'hC3;
        endcase
        return v;
    endfunction

    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < 32768; i++) mem[i] <= preload(i);
            mem_ready  <= 1'b1;
            vram_rdata <= 8'h00;
        end else begin
            if (vram_we) mem[vram_addr] <= vram_wdata;
            vram_rdata <= mem[vram_addr];
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; video_clock_enable = 1'b0; crtc_ma = 14'h0000; crtc_de = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0005; cpu_wdata = 8'hEE;
        repeat (3) next_cycle();
        sample();
        checks++; if ({cpu_ack, fetch_valid, vram_we} !== 3'b000) begin errors++; $display("FAIL rst_strobes: got %b want 000", {cpu_ack, fetch_valid, vram_we}); end
        checks++; if ({cpu_rdata, char_code, attr_code} !== 24'h000000) begin errors++; $display("FAIL rst_data: got %h want 000000", {cpu_rdata, char_code, attr_code}); end
        checks++; if ({vram_addr, vram_wdata} !== 23'h000000) begin errors++; $display("FAIL rst_ram_port: got %h want 000000", {vram_addr, vram_wdata}); end
        next_cycle(); cpu_we = 1'b0;
        next_cycle(); reset_n = 1'b1;            // release cycle
        sample();
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rst_rel_ack0: got %b want 0", cpu_ack); end
        next_cycle();                            // release + 1: issue
        sample();
        checks++; if (vram_addr !== 15'h0005) begin errors++; $display("FAIL rst_issue_addr: got %h want 0005", vram_addr); end
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rst_rel_ack1: got %b want 0", cpu_ack); end
        next_cycle();                            // release + 2: ack
        sample();
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL rst_rel_ack2: got %b want 1", cpu_ack); end
        checks++; if (cpu_rdata !== 8'h37) begin errors++; $display("FAIL rst_rel_rdata: got %h want 37", cpu_rdata); end
        next_cycle(); cpu_req = 1'b0;
        sample();
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rst_ack_pulse: got %b want 0", cpu_ack); end
        checks++; if (cpu_rdata !== 8'h37) begin errors++; $display("FAIL rst_rdata_hold: got %h want 37", cpu_rdata); end
    endtask

    task automatic test_video_fetch();
        next_cycle(); video_clock_enable = 1'b1; crtc_de = 1'b1; crtc_ma = 14'h0123;
        next_cycle(); video_clock_enable = 1'b0;             // phase 0
        sample();
        checks++; if (vram_addr !== 15'h0246) begin errors++; $display("FAIL vf_char_addr: got %h want 0246", vram_addr); end
        checks++; if ({vram_we, fetch_valid} !== 2'b00) begin errors++; $display("FAIL vf_p0_we_fv: got %b want 00", {vram_we, fetch_valid}); end
        next_cycle();                                        // phase 1
        sample();
        checks++; if (vram_addr !== 15'h0247) begin errors++; $display("FAIL vf_attr_addr: got %h want 0247", vram_addr); end
        next_cycle();                                        // phase 2
        sample();
        checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL vf_fv: got %b want 1", fetch_valid); end
        checks++; if (char_code !== 8'h41) begin errors++; $display("FAIL vf_char: got %h want 41", char_code); end
        checks++; if (attr_code !== 8'h1F) begin errors++; $display("FAIL vf_attr: got %h want 1f", attr_code); end
        next_cycle(); video_clock_enable = 1'b1;             // phase 3
        sample();
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL vf_fv_pulse: got %b want 0", fetch_valid); end
        checks++; if (attr_code !== 8'h1F) begin errors++; $display("FAIL vf_attr_hold: got %h want 1f", attr_code); end
        checks++; if (vram_addr !== 15'h0247) begin errors++; $display("FAIL vf_idle_addr: got %h want 0247", vram_addr); end
    endtask

    task automatic test_cpu_write();
        next_cycle(); video_clock_enable = 1'b0;             // phase 0, request
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0010; cpu_wdata = 8'h5A;
        sample();
        checks++; if ({vram_addr, vram_we, cpu_ack} !== {15'h0246, 2'b00}) begin errors++; $display("FAIL wr_p0_video: got %h/%b/%b want 0246/0/0", vram_addr, vram_we, cpu_ack); end
        next_cycle();                                        // phase 1
        sample();
        checks++; if ({vram_addr, vram_we, cpu_ack} !== {15'h0247, 2'b00}) begin errors++; $display("FAIL wr_p1_video: got %h/%b/%b want 0247/0/0", vram_addr, vram_we, cpu_ack); end
        next_cycle();                                        // phase 2: issue
        sample();
        checks++; if ({vram_addr, vram_we, vram_wdata} !== {15'h0010, 1'b1, 8'h5A}) begin errors++; $display("FAIL wr_issue: got %h/%b/%h want 0010/1/5a", vram_addr, vram_we, vram_wdata); end
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL wr_issue_ack: got %b want 0", cpu_ack); end
        next_cycle(); video_clock_enable = 1'b1;             // phase 3: ack
        sample();
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL wr_ack: got %b want 1", cpu_ack); end
        checks++; if (vram_we !== 1'b0) begin errors++; $display("FAIL wr_no_reissue: got %b want 0", vram_we); end
        checks++; if (cpu_rdata !== 8'h37) begin errors++; $display("FAIL wr_rdata_unchanged: got %h want 37", cpu_rdata); end
        next_cycle(); video_clock_enable = 1'b0; cpu_we = 1'b0;   // phase 0, read back
        sample();
        checks++; if ({cpu_ack, vram_addr} !== {1'b0, 15'h0246}) begin errors++; $display("FAIL rd_p0: got %b/%h want 0/0246", cpu_ack, vram_addr); end
        next_cycle();                                        // phase 1
        next_cycle();                                        // phase 2: issue
        sample();
        checks++; if ({vram_addr, vram_we} !== {15'h0010, 1'b0}) begin errors++; $display("FAIL rd_issue: got %h/%b want 0010/0", vram_addr, vram_we); end
        next_cycle(); video_clock_enable = 1'b1;             // phase 3: ack
        sample();
        checks++; if ({cpu_ack, cpu_rdata} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL rd_readback: got %b/%h want 1/5a", cpu_ack, cpu_rdata); end
        next_cycle(); video_clock_enable = 1'b0; cpu_req = 1'b0;
    endtask

    task automatic test_period2();
        next_cycle(); video_clock_enable = 1'b1;
        next_cycle(); video_clock_enable = 1'b0;             // phase 0, displaying
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0005;
        sample();
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL p2_starve_first: got %b want 0", cpu_ack); end
        for (int k = 2; k <= 10; k++) begin
            next_cycle();
            video_clock_enable = ((k % 2) == 0) ? 1'b1 : 1'b0;
            if (k == 10) crtc_de = 1'b0;
            sample();
            checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL p2_starve k=%0d: got %b want 0", k, cpu_ack); end
        end
        next_cycle(); video_clock_enable = 1'b0;             // phase 0, DE latched low
        sample();
        checks++; if (vram_addr !== 15'h0005) begin errors++; $display("FAIL p2_blank_issue: got %h want 0005", vram_addr); end
        next_cycle(); video_clock_enable = 1'b1;             // phase 1
        sample();
        checks++; if ({cpu_ack, cpu_rdata} !== {1'b1, 8'h37}) begin errors++; $display("FAIL p2_blank_ack: got %b/%h want 1/37", cpu_ack, cpu_rdata); end
        next_cycle(); video_clock_enable = 1'b0; cpu_req = 1'b0;
        sample();
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL p2_fv_a: got %b want 0", fetch_valid); end
        next_cycle(); video_clock_enable = 1'b1;
        sample();
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL p2_fv_b: got %b want 0", fetch_valid); end
        checks++; if ({char_code, attr_code} !== 16'h411F) begin errors++; $display("FAIL p2_codes_hold: got %h want 411f", {char_code, attr_code}); end
        next_cycle(); video_clock_enable = 1'b0;
        sample();
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL p2_fv_c: got %b want 0", fetch_valid); end
    endtask

    task automatic test_back_to_back();
        next_cycle(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0001;
        sample();
        checks++; if ({vram_addr, cpu_ack} !== {15'h0001, 1'b0}) begin errors++; $display("FAIL b2b_issue1: got %h/%b want 0001/0", vram_addr, cpu_ack); end
        next_cycle();
        sample();
        checks++; if ({cpu_ack, cpu_rdata} !== {1'b1, 8'h11}) begin errors++; $display("FAIL b2b_ack1: got %b/%h want 1/11", cpu_ack, cpu_rdata); end
        checks++; if ({vram_addr, vram_we} !== {15'h0001, 1'b0}) begin errors++; $display("FAIL b2b_gap_hold: got %h/%b want 0001/0", vram_addr, vram_we); end
        next_cycle(); cpu_addr = 15'h0002;
        sample();
        checks++; if ({vram_addr, cpu_ack, cpu_rdata} !== {15'h0002, 1'b0, 8'h11}) begin errors++; $display("FAIL b2b_issue2: got %h/%b/%h want 0002/0/11", vram_addr, cpu_ack, cpu_rdata); end
        next_cycle();
        sample();
        checks++; if ({cpu_ack, cpu_rdata} !== {1'b1, 8'h22}) begin errors++; $display("FAIL b2b_ack2: got %b/%h want 1/22", cpu_ack, cpu_rdata); end
        next_cycle(); cpu_req = 1'b0;
        sample();
        checks++; if ({cpu_ack, cpu_rdata} !== {1'b0, 8'h22}) begin errors++; $display("FAIL b2b_end: got %b/%h want 0/22", cpu_ack, cpu_rdata); end
    endtask

    task automatic test_reset_mid();
        next_cycle(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0010;
        sample();
        checks++; if (vram_addr !== 15'h0010) begin errors++; $display("FAIL rm_issue: got %h want 0010", vram_addr); end
        reset_n = 1'b0;
        #1;
        checks++; if ({cpu_ack, cpu_rdata, char_code, attr_code} !== 25'h0) begin errors++; $display("FAIL rm_async_clear: got %b/%h/%h/%h want 0/00/00/00", cpu_ack, cpu_rdata, char_code, attr_code); end
        next_cycle();
        sample();
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rm_no_ack: got %b want 0", cpu_ack); end
        next_cycle(); reset_n = 1'b1;
        sample();
        checks++; if ({cpu_ack, vram_we} !== 2'b00) begin errors++; $display("FAIL rm_release: got %b want 00", {cpu_ack, vram_we}); end
        next_cycle();
        sample();
        checks++; if ({vram_addr, cpu_ack} !== {15'h0010, 1'b0}) begin errors++; $display("FAIL rm_reissue: got %h/%b want 0010/0", vram_addr, cpu_ack); end
        next_cycle();
        sample();
        checks++; if ({cpu_ack, cpu_rdata} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL rm_reack: got %b/%h want 1/5a", cpu_ack, cpu_rdata); end
        next_cycle(); cpu_req = 1'b0;
        sample();
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rm_end: got %b want 0", cpu_ack); end
    endtask

    initial begin
        test_reset();
        test_video_fetch();
        test_cpu_write();
        test_period2();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
